tos_uart_tx: RTL and testbench

Parametrised framed UART transmitter for the ternary processor's result word. Runs in the board-clock domain beside the processor core and is fired by a rising edge on its start input, normally tied to the processor's halted flag. It captures a WORD_W-bit top-of-stack value and sends it as a framed packet: sync byte, data bytes LSB-first, XOR checksum. It replaces the fixed 8-bit, level-retriggered result stub with configurable width, baud, stop bits and byte order, plus a ready/done handshake.

---
 rtl/ternary_pkg.sv | 38 +++
 rtl/baud_tick_gen.sv | 41 ++++
 rtl/tos_uart_tx.sv | 205 ++++++++++++++++++++
 tb/tb_tos_uart_tx.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ternary_pkg.sv
// ---------------------------------------------------------------------------
// ternary_pkg
// Shared definitions for the ternary processor result path:
//   - SYNC_BYTE      : first byte of every result packet on the UART line
//   - tx_state_t     : packet-level FSM states of the result transmitter
//   - bit_phase_t    : per-byte bit phases (start bit, data bits, stop bits)
//   - TRIT_*         : two-bit trit encoding shared with the processor core,
//                      consumed by the LED/trit decode logic in the wrapper
//   - bytes_for()    : number of whole bytes needed to carry a bit width
// ---------------------------------------------------------------------------
package ternary_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_CHK
   } tx_state_t;

   typedef enum logic [1:0] {
      PH_START,
      PH_BITS,
      PH_STOP
   } bit_phase_t;

   // Trit encoding used by the core: one trit per two-bit field.
   localparam int         TRIT_W    = 2;
   localparam logic [1:0] TRIT_ZERO = 2'b00;
   localparam logic [1:0] TRIT_POS  = 2'b01;
   localparam logic [1:0] TRIT_NEG  = 2'b10;

   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// ---------------------------------------------------------------------------
// baud_tick_gen
// Free-running bit-period counter 0..CLK_DIV-1 with a one-cycle tick on the
// last count. Shared with the UART RX program loader.
// Ports:
//   clk_in  in   board clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   synchronous clear of the count to 0 (suppresses the tick)
//   en      in   count enable; the count holds while low
//   tick    out  high while count == CLK_DIV-1 and en is high
// ---------------------------------------------------------------------------
module baud_tick_gen #(
   parameter int CLK_DIV = 1250
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_at_last;

   assign w_at_last = (r_count == CNT_LAST);
   assign tick      = en & ~clr & w_at_last;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= w_at_last ? '0 : r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/tos_uart_tx.sv
// ---------------------------------------------------------------------------
// tos_uart_tx
// Framed UART transmitter for the processor's top-of-stack result word.
// A rising edge on start (while ready) captures word and sends:
//   0xA5, NBYTES data bytes (LSB- or MSB-byte first), XOR of the data bytes.
// Each byte: one start bit (0), 8 data bits LSB-first, STOP_BITS ones.
// Ports:
//   clk_in   in   board clock
//   rst_n    in   asynchronous active-low reset
//   start    in   transfer request, acted on at its rising edge only
//   word     in   WORD_W-bit value, sampled in the acceptance cycle
//   ready    out  idle, a start edge now is accepted
//   busy     out  packet in progress (~ready)
//   done     out  one-cycle pulse after the final stop bit
//   uart_tx  out  serial line, idles high
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module tos_uart_tx #(
   parameter int CLK_DIV        = 1250,
   parameter int WORD_W         = 18,
   parameter int STOP_BITS      = 1,
   parameter int LSB_BYTE_FIRST = 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              start,
   input  logic [WORD_W-1:0] word,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic              uart_tx
);

   import ternary_pkg::*;

   localparam int               NBYTES    = bytes_for(WORD_W);
   localparam int               PAD_W     = NBYTES * 8;
   localparam int               IDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
   localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

   tx_state_t        r_state, w_state_next;
   bit_phase_t       r_phase, w_phase_next;
   logic             r_start_q;
   logic [PAD_W-1:0] r_word, w_word_next, w_word_pad;
   logic [7:0]       r_shift, w_shift_next;
   logic [7:0]       r_chk, w_chk_next;
   logic [2:0]       r_bit_cnt, w_bit_cnt_next;
   logic [IDX_W-1:0] r_byte_idx, w_byte_idx_next;
   logic             r_tx, w_tx_next;
   logic             r_ready, w_ready_next;
   logic             r_busy, w_busy_next;
   logic             r_done, w_done_next;

   logic             w_rise;
   logic             w_tick;
   logic             w_baud_clr;
   logic [IDX_W-1:0] w_load_idx;
   logic [IDX_W-1:0] w_load_sel;
   logic [7:0]       w_load_byte;
   logic [7:0]       w_bytes [NBYTES];

   // Split the padded word into addressable bytes (byte 0 = word[7:0]).
   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
         assign w_bytes[gi] = r_word[gi*8 +: 8];
      end
   endgenerate

   assign w_rise = start & ~r_start_q;

   // Next data byte: index 0 after the sync byte, otherwise the following one.
   assign w_load_idx  = (r_state == ST_SYNC) ? '0 : r_byte_idx + IDX_W'(1);
   assign w_load_sel  = (LSB_BYTE_FIRST != 0) ? w_load_idx : LAST_IDX - w_load_idx;
   assign w_load_byte = w_bytes[w_load_sel];

   baud_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .clr    (w_baud_clr),
      .en     (r_busy),
      .tick   (w_tick)
   );

   always_comb begin
      w_word_pad               = '0;
      w_word_pad[WORD_W-1:0]   = word;

      w_state_next    = r_state;
      w_phase_next    = r_phase;
      w_word_next     = r_word;
      w_shift_next    = r_shift;
      w_chk_next      = r_chk;
      w_bit_cnt_next  = r_bit_cnt;
      w_byte_idx_next = r_byte_idx;
      w_tx_next       = r_tx;
      w_ready_next    = r_ready;
      w_busy_next     = r_busy;
      w_done_next     = 1'b0;
      w_baud_clr      = 1'b0;

      if (r_state == ST_IDLE) begin
         if (w_rise) begin
            w_word_next     = w_word_pad;
            w_chk_next      = '0;
            w_state_next    = ST_SYNC;
            w_phase_next    = PH_START;
            w_shift_next    = SYNC_BYTE;
            w_bit_cnt_next  = '0;
            w_byte_idx_next = '0;
            w_tx_next       = 1'b0;      // start bit appears the next cycle
            w_ready_next    = 1'b0;
            w_busy_next     = 1'b1;
            w_baud_clr      = 1'b1;
         end
      end else if (w_tick) begin
         case (r_phase)
            PH_START: begin
               w_tx_next      = r_shift[0];
               w_phase_next   = PH_BITS;
               w_bit_cnt_next = '0;
            end
            PH_BITS: begin
               if (r_bit_cnt == 3'd7) begin
                  w_tx_next      = 1'b1;
                  w_phase_next   = PH_STOP;
                  w_bit_cnt_next = '0;
               end else begin
                  w_tx_next      = r_shift[1];
                  w_shift_next   = {1'b0, r_shift[7:1]};
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
               end
            end
            PH_STOP: begin
               if (r_bit_cnt != LAST_STOP) begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
               end else begin
                  w_bit_cnt_next = '0;
                  if (r_state == ST_CHK) begin
                     w_state_next = ST_IDLE;
                     w_phase_next = PH_START;
                     w_ready_next = 1'b1;
                     w_busy_next  = 1'b0;
                     w_done_next  = 1'b1;
                  end else begin
                     // Next byte's start bit follows the stop bit directly.
                     w_phase_next = PH_START;
                     w_tx_next    = 1'b0;
                     if (r_state == ST_DATA && r_byte_idx == LAST_IDX) begin
                        w_state_next = ST_CHK;
                        w_shift_next = r_chk;
                     end else begin
                        w_state_next    = ST_DATA;
                        w_byte_idx_next = w_load_idx;
                        w_shift_next    = w_load_byte;
                        w_chk_next      = r_chk ^ w_load_byte;
                     end
                  end
               end
            end
            default: begin
               w_phase_next = PH_START;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_phase    <= PH_START;
         r_start_q  <= 1'b0;
         r_word     <= '0;
         r_shift    <= '0;
         r_chk      <= '0;
         r_bit_cnt  <= '0;
         r_byte_idx <= '0;
         r_tx       <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_phase    <= w_phase_next;
         r_start_q  <= start;
         r_word     <= w_word_next;
         r_shift    <= w_shift_next;
         r_chk      <= w_chk_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_byte_idx <= w_byte_idx_next;
         r_tx       <= w_tx_next;
         r_ready    <= w_ready_next;
         r_busy     <= w_busy_next;
         r_done     <= w_done_next;
      end
   end

   assign ready   = r_ready;
   assign busy    = r_busy;
   assign done    = r_done;
   assign uart_tx = r_tx;

endmodule

// File: tb/tb_tos_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_tos_uart_tx
// Five transmitter instances (CLK_DIV=4) covering byte order, stop bits and
// word widths; a UART line decoder compares received bytes against a queue
// of expected bytes pushed when each transfer is started.
//   0: WORD_W=18, 1 stop, LSB first     1: WORD_W=18, 1 stop, MSB first
//   2: WORD_W=18, 2 stop, LSB first     3: WORD_W=8                4: WORD_W=24
// ---------------------------------------------------------------------------
module tb_tos_uart_tx;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  start_v;
   logic [17:0] word18;
   logic [7:0]  word8;
   logic [23:0] word24;
   wire  [4:0]  ready_v;
   wire  [4:0]  busy_v;
   wire  [4:0]  done_v;
   wire  [4:0]  tx_v;

   always #5 clk = ~clk;

   tos_uart_tx #(.CLK_DIV(DIV), .WORD_W(18), .STOP_BITS(1), .LSB_BYTE_FIRST(1)) u_dut0 (
      .clk_in(clk), .rst_n(rst_n), .start(start_v[0]), .word(word18),
      .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .uart_tx(tx_v[0]));
   tos_uart_tx #(.CLK_DIV(DIV), .WORD_W(18), .STOP_BITS(1), .LSB_BYTE_FIRST(0)) u_dut1 (
      .clk_in(clk), .rst_n(rst_n), .start(start_v[1]), .word(word18),
      .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .uart_tx(tx_v[1]));
   tos_uart_tx #(.CLK_DIV(DIV), .WORD_W(18), .STOP_BITS(2), .LSB_BYTE_FIRST(1)) u_dut2 (
      .clk_in(clk), .rst_n(rst_n), .start(start_v[2]), .word(word18),
      .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]), .uart_tx(tx_v[2]));
   tos_uart_tx #(.CLK_DIV(DIV), .WORD_W(8), .STOP_BITS(1), .LSB_BYTE_FIRST(1)) u_dut3 (
      .clk_in(clk), .rst_n(rst_n), .start(start_v[3]), .word(word8),
      .ready(ready_v[3]), .busy(busy_v[3]), .done(done_v[3]), .uart_tx(tx_v[3]));
   tos_uart_tx #(.CLK_DIV(DIV), .WORD_W(24), .STOP_BITS(1), .LSB_BYTE_FIRST(1)) u_dut4 (
      .clk_in(clk), .rst_n(rst_n), .start(start_v[4]), .word(word24),
      .ready(ready_v[4]), .busy(busy_v[4]), .done(done_v[4]), .uart_tx(tx_v[4]));

   typedef struct {
      logic [7:0] data;
      bit         frame_ok;
   } rx_t;

   rx_t        rx_q [$];
   logic [7:0] exp_q [$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         cyc      = 0;
   int         drop_cyc = 0;
   bit         rx_timeout;
   int         done_cnt [5]      = '{0, 0, 0, 0, 0};
   int         done_cyc [5]      = '{0, 0, 0, 0, 0};
   logic       ready_at_done [5] = '{0, 0, 0, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int k = 0; k < 5; k++) begin
         if (done_v[k] === 1'b1) begin
            done_cnt[k]      <= done_cnt[k] + 1;
            done_cyc[k]      <= cyc;
            ready_at_done[k] <= ready_v[k];
         end
      end
   end

   // Decode nbytes frames from line k; every bit must hold for DIV cycles and
   // bytes after the first must start with no idle gap.
   task automatic rx_packet(input int k, input int nbytes, input int stop_bits);
      rx_t        r;
      logic [7:0] d;
      logic       first;
      bit         ok;
      int         wait_n;
      rx_timeout = 1'b0;
      for (int b = 0; b < nbytes; b++) begin
         wait_n = 0;
         while (tx_v[k] !== 1'b0 && wait_n < 2000) begin
            @(negedge clk);
            wait_n++;
         end
         if (tx_v[k] !== 1'b0) begin
            rx_timeout = 1'b1;
            return;
         end
         if (b == 0) drop_cyc = cyc;
         ok = (b == 0) || (wait_n == 0);
         d  = '0;
         for (int bi = 0; bi < 9 + stop_bits; bi++) begin
            first = tx_v[k];
            for (int c = 0; c < DIV; c++) begin
               if (tx_v[k] !== first) ok = 1'b0;
               @(negedge clk);
            end
            if (bi == 0 && first !== 1'b0) ok = 1'b0;
            if (bi >= 1 && bi <= 8) d[bi-1] = first;
            if (bi >= 9 && first !== 1'b1) ok = 1'b0;
         end
         r.data     = d;
         r.frame_ok = ok;
         rx_q.push_back(r);
      end
   endtask

   task automatic fire(input int k);
      @(negedge clk);
      start_v[k] = 1'b1;
      @(negedge clk);
      start_v[k] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start_v = '0;
      word18  = 18'h25A3C;
      word8   = 8'h00;
      word24  = 24'hFFFFFF;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if ({tx_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100)
            $display("FAIL reset_outputs dut%0d: tx/ready/busy/done=%b, expected 1100", k,
                     {tx_v[k], ready_v[k], busy_v[k], done_v[k]});
         else n_pass++;
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      $display("test_reset: %0d checks", n_checks);
   endtask

   task automatic test_basic();
      rx_t        r;
      logic [7:0] e;
      int         n, d0;
      d0 = done_cnt[0];
      rx_q.delete();
      exp_q = '{8'hA5, 8'h3C, 8'h5A, 8'h02, 8'h64};
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      n_checks++;
      if (tx_v[0] !== 1'b0 || ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1)
         $display("FAIL basic_first_cycle: tx=%b ready=%b busy=%b, expected tx=0 ready=0 busy=1",
                  tx_v[0], ready_v[0], busy_v[0]);
      else n_pass++;
      start_v[0] = 1'b0;
      rx_packet(0, 5, 1);
      repeat (5) @(negedge clk);
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (rx_q.size() == 0) $display("FAIL basic_byte%0d: got nothing, expected %02h", i, e);
         else begin
            r = rx_q.pop_front();
            if (r.data !== e || !r.frame_ok)
               $display("FAIL basic_byte%0d: got %02h frame_ok=%0d, expected %02h frame_ok=1", i, r.data, r.frame_ok, e);
            else n_pass++;
         end
      end
      n_checks++;
      if (rx_timeout || done_cyc[0] - drop_cyc != 200)
         $display("FAIL basic_done_latency: got %0d (timeout=%0d), expected 200", done_cyc[0] - drop_cyc, rx_timeout);
      else n_pass++;
      n_checks++;
      if (ready_at_done[0] !== 1'b1 || done_cnt[0] - d0 != 1)
         $display("FAIL basic_done_ready: ready=%b pulses=%0d, expected ready=1 pulses=1", ready_at_done[0], done_cnt[0] - d0);
      else n_pass++;
      $display("test_basic: %0d checks", n_checks);
   endtask

   // Byte order, stop bits and widths: instance, expected bytes, latency.
   task automatic test_config(input int k, input int stop_bits, input int latency);
      rx_t        r;
      logic [7:0] e;
      int         n;
      rx_q.delete();
      case (k)
         1:       exp_q = '{8'hA5, 8'h02, 8'h5A, 8'h3C, 8'h64};
         2:       exp_q = '{8'hA5, 8'h3C, 8'h5A, 8'h02, 8'h64};
         3:       exp_q = '{8'hA5, 8'h00, 8'h00};
         default: exp_q = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      endcase
      n = exp_q.size();
      fire(k);
      rx_packet(k, n, stop_bits);
      repeat (5) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         n_checks++;
         if (rx_q.size() == 0) $display("FAIL cfg%0d_byte%0d: got nothing, expected %02h", k, i, e);
         else begin
            r = rx_q.pop_front();
            if (r.data !== e || !r.frame_ok)
               $display("FAIL cfg%0d_byte%0d: got %02h frame_ok=%0d, expected %02h frame_ok=1", k, i, r.data, r.frame_ok, e);
            else n_pass++;
         end
      end
      n_checks++;
      if (rx_timeout || done_cyc[k] - drop_cyc != latency)
         $display("FAIL cfg%0d_done_latency: got %0d (timeout=%0d), expected %0d", k, done_cyc[k] - drop_cyc, rx_timeout, latency);
      else n_pass++;
      $display("test_config dut%0d: %0d checks", k, n_checks);
   endtask

   task automatic test_hold_start();
      rx_t r;
      int  d0, lows;
      d0 = done_cnt[0];
      rx_q.delete();
      @(negedge clk);
      start_v[0] = 1'b1;
      exp_q = '{8'hA5, 8'h3C, 8'h5A, 8'h02, 8'h64};
      rx_packet(0, 5, 1);
      lows = 0;
      for (int i = 0; i < 800; i++) begin
         if (tx_v[0] !== 1'b1) lows++;
         @(negedge clk);
      end
      start_v[0] = 1'b0;
      n_checks++;
      if (lows != 0 || done_cnt[0] - d0 != 1 || rx_q.size() != 5)
         $display("FAIL hold_single_packet: low samples=%0d packets=%0d bytes=%0d, expected 0 1 5", lows, done_cnt[0] - d0, rx_q.size());
      else n_pass++;
      for (int i = 0; i < 5 && rx_q.size() > 0; i++) begin
         r = rx_q.pop_front();
         n_checks++;
         if (r.data !== exp_q[i] || !r.frame_ok)
            $display("FAIL hold_byte%0d: got %02h, expected %02h", i, r.data, exp_q[i]);
         else n_pass++;
      end
      // Drop and raise again: a fresh edge sends a second packet.
      repeat (2) @(negedge clk);
      start_v[0] = 1'b1;
      exp_q = '{8'hA5, 8'h3C, 8'h5A, 8'h02, 8'h64};
      rx_packet(0, 5, 1);
      start_v[0] = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (rx_timeout || done_cnt[0] - d0 != 2 || rx_q.size() != 5 || rx_q[1].data !== exp_q[1])
         $display("FAIL hold_second_packet: packets=%0d bytes=%0d, expected packets=2 bytes=5", done_cnt[0] - d0, rx_q.size());
      else n_pass++;
      exp_q.delete();
      $display("test_hold_start: %0d checks", n_checks);
   endtask

   task automatic test_mid_edge();
      rx_t r;
      int  d0, lows;
      d0 = done_cnt[0];
      rx_q.delete();
      exp_q = '{8'hA5, 8'h3C, 8'h5A, 8'h02, 8'h64};
      fire(0);
      fork
         rx_packet(0, 5, 1);
         begin
            repeat (60) @(negedge clk);
            start_v[0] = 1'b1;
            @(negedge clk);
            start_v[0] = 1'b0;
         end
      join
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (rx_q.size() == 0) $display("FAIL midedge_byte%0d: got nothing, expected %02h", i, exp_q[i]);
         else begin
            r = rx_q.pop_front();
            if (r.data !== exp_q[i] || !r.frame_ok)
               $display("FAIL midedge_byte%0d: got %02h, expected %02h", i, r.data, exp_q[i]);
            else n_pass++;
         end
      end
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         if (tx_v[0] !== 1'b1) lows++;
         @(negedge clk);
      end
      n_checks++;
      if (lows != 0 || done_cnt[0] - d0 != 1)
         $display("FAIL midedge_no_retrigger: low samples=%0d packets=%0d, expected 0 1", lows, done_cnt[0] - d0);
      else n_pass++;
      exp_q.delete();
      $display("test_mid_edge: %0d checks", n_checks);
   endtask

   task automatic test_reset_mid();
      int d0, lows;
      fire(0);
      d0 = done_cnt[0];
      repeat (80) @(negedge clk);     // now inside data byte 1's start bit
      n_checks++;
      if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1)
         $display("FAIL rstmid_precondition: tx=%b busy=%b, expected tx=0 busy=1", tx_v[0], busy_v[0]);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tx_v[0], ready_v[0], busy_v[0], done_v[0]} !== 4'b1100)
         $display("FAIL rstmid_async: tx/ready/busy/done=%b, expected 1100", {tx_v[0], ready_v[0], busy_v[0], done_v[0]});
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         if (tx_v[0] !== 1'b1 || ready_v[0] !== 1'b1) lows++;
         @(negedge clk);
      end
      n_checks++;
      if (lows != 0 || done_cnt[0] != d0)
         $display("FAIL rstmid_stays_idle: non-idle samples=%0d done pulses=%0d, expected 0 0", lows, done_cnt[0] - d0);
      else n_pass++;
      $display("test_reset_mid: %0d checks", n_checks);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_config(1, 1, 200);
      test_config(2, 2, 220);
      test_config(3, 1, 120);
      test_config(4, 1, 200);
      test_hold_start();
      test_mid_edge();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
